// File: rtl/bt656_frame_encoder.sv
// -----------------------------------------------------------------------------
// bt656_frame_encoder
//
// Produces a 625-line interlaced ITU-R BT.656 byte stream: EAV/SAV timing
// codes, 80/10 blanking fill, and active video pulled from the frame-buffer
// read path. One byte per 27 MHz clock.
//
// Ports:
//   clk         27 MHz byte clock
//   rst         asynchronous reset, active-high
//   en          run enable; low parks the generator at line 1, pos 0
//   pix_data    active-video byte, valid the cycle after pix_rd
//   pix_rd      request for the next active byte (combinational from counters)
//   bt_data     registered BT.656 byte stream
//   field       F bit of the byte on bt_data
//   vblank      V bit of the byte on bt_data
//   hblank      high while the byte on bt_data is outside the active window
//   frame_start one-cycle pulse with the FF of the line-1 EAV
//   line_num    line (1..625) of the byte on bt_data
// -----------------------------------------------------------------------------
module bt656_frame_encoder #(
  parameter int LINE_BYTES   = 1728,
  parameter int ACTIVE_BYTES = 1440
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] pix_data,
  output logic       pix_rd,
  output logic [7:0] bt_data,
  output logic       field,
  output logic       vblank,
  output logic       hblank,
  output logic       frame_start,
  output logic [9:0] line_num
);

  // First active byte position; both widths are even so A0 is even and the
  // fill pattern can key directly off pos[0].
  localparam logic [10:0] A0       = 11'(LINE_BYTES - ACTIVE_BYTES);
  localparam logic [10:0] SAV_FF   = 11'(LINE_BYTES - ACTIVE_BYTES - 4);
  localparam logic [10:0] SAV_Z1   = 11'(LINE_BYTES - ACTIVE_BYTES - 3);
  localparam logic [10:0] SAV_Z2   = 11'(LINE_BYTES - ACTIVE_BYTES - 2);
  localparam logic [10:0] SAV_XY   = 11'(LINE_BYTES - ACTIVE_BYTES - 1);
  localparam logic [10:0] POS_LAST = 11'(LINE_BYTES - 1);
  localparam logic [10:0] RD_LAST  = 11'(LINE_BYTES - 2);

  function automatic logic [7:0] timing_xy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // 00 and FF are reserved for timing codes and must never appear in video.
  function automatic logic [7:0] clip_video(input logic [7:0] b);
    if (b == 8'h00)      return 8'h01;
    else if (b == 8'hFF) return 8'hFE;
    else                 return b;
  endfunction

  logic [10:0] pos_q, pos_d;
  logic [9:0]  line_q, line_d;
  logic [7:0]  bt_data_q, bt_data_d;
  logic        field_q, field_d;
  logic        vblank_q, vblank_d;
  logic        hblank_q, hblank_d;
  logic        frame_start_q, frame_start_d;
  logic [9:0]  line_num_q, line_num_d;

  logic        f_cur;
  logic        v_cur;
  logic [7:0]  byte_cur;

  always_comb begin
    f_cur = (line_q >= 10'd313);
    v_cur = (line_q <= 10'd22) || ((line_q >= 10'd311) && (line_q <= 10'd335)) ||
            (line_q >= 10'd624);

    // Strobe one cycle ahead of each active byte so pix_data lands in time.
    pix_rd = en && !v_cur && (pos_q >= SAV_XY) && (pos_q <= RD_LAST);

    if ((pos_q == 11'd0) || (pos_q == SAV_FF)) begin
      byte_cur = 8'hFF;
    end else if ((pos_q == 11'd1) || (pos_q == 11'd2) ||
                 (pos_q == SAV_Z1) || (pos_q == SAV_Z2)) begin
      byte_cur = 8'h00;
    end else if (pos_q == 11'd3) begin
      byte_cur = timing_xy(f_cur, v_cur, 1'b1);
    end else if (pos_q == SAV_XY) begin
      byte_cur = timing_xy(f_cur, v_cur, 1'b0);
    end else if ((pos_q >= A0) && !v_cur) begin
      byte_cur = clip_video(pix_data);
    end else begin
      byte_cur = pos_q[0] ? 8'h10 : 8'h80;
    end

    pos_d         = 11'd0;
    line_d        = 10'd1;
    bt_data_d     = 8'h10;
    field_d       = 1'b0;
    vblank_d      = 1'b1;
    hblank_d      = 1'b1;
    frame_start_d = 1'b0;
    line_num_d    = 10'd1;

    if (en) begin
      if (pos_q == POS_LAST) begin
        pos_d  = 11'd0;
        line_d = (line_q == 10'd625) ? 10'd1 : line_q + 10'd1;
      end else begin
        pos_d  = pos_q + 11'd1;
        line_d = line_q;
      end
      bt_data_d     = byte_cur;
      field_d       = f_cur;
      vblank_d      = v_cur;
      hblank_d      = (pos_q < A0);
      frame_start_d = (pos_q == 11'd0) && (line_q == 10'd1);
      line_num_d    = line_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q         <= 11'd0;
      line_q        <= 10'd1;
      bt_data_q     <= 8'h10;
      field_q       <= 1'b0;
      vblank_q      <= 1'b1;
      hblank_q      <= 1'b1;
      frame_start_q <= 1'b0;
      line_num_q    <= 10'd1;
    end else begin
      pos_q         <= pos_d;
      line_q        <= line_d;
      bt_data_q     <= bt_data_d;
      field_q       <= field_d;
      vblank_q      <= vblank_d;
      hblank_q      <= hblank_d;
      frame_start_q <= frame_start_d;
      line_num_q    <= line_num_d;
    end
  end

  assign bt_data     = bt_data_q;
  assign field       = field_q;
  assign vblank      = vblank_q;
  assign hblank      = hblank_q;
  assign frame_start = frame_start_q;
  assign line_num    = line_num_q;

endmodule

// File: doc/bt656_frame_encoder.md
Name: bt656_frame_encoder

Overview:
Transmit-side counterpart of the BT.656 decode path. Generates a complete 625-line interlaced ITU-R BT.656 byte stream for the ADV7179 encoder, including EAV/SAV timing codes, horizontal and vertical blanking fill, and field sequencing. Active-video bytes are pulled from the SRAM read path through a fixed-latency read strobe. It sits between the frame-buffer read side of the SRAM bus controller and the output clock/data control stage, and is clocked from the 27 MHz pixel clock domain.

Parameters:
LINE_BYTES, 1728, total bytes per line including EAV, blanking, SAV and active video (must be even).
ACTIVE_BYTES, 1440, active-video bytes per line: 720 pixels, Cb Y Cr Y order (must be even; LINE_BYTES-ACTIVE_BYTES >= 10).

Ports:
clk  input  1  27 MHz byte clock.
rst  input  1  asynchronous reset, active-high.
en  input  1  run enable (config done); low holds the timing generator at frame start.
pix_data  input  8  active-video byte, valid the cycle after pix_rd.
pix_rd  output  1  request for the next active byte.
bt_data  output  8  registered BT.656 byte stream.
field  output  1  current F bit.
vblank  output  1  current V bit.
hblank  output  1  high outside the active-byte window.
frame_start  output  1  one-cycle pulse at line 1, pos 0.
line_num  output  10  current line, 1..625.

Behaviour:
- Internal counters:
  - pos: 11 bits, 0..LINE_BYTES-1; wraps to 0 and increments line.
  - line: 10 bits, 1..625; wraps 625->1.
  - A0 = LINE_BYTES-ACTIVE_BYTES.
- Line layout by pos:
  - 0..3: EAV = FF 00 00 XY with H=1.
  - 4..A0-5: blanking fill.
  - A0-4..A0-1: SAV = FF 00 00 XY with H=0.
  - A0..LINE_BYTES-1: active window.
- XY = {1,F,V,H,V^H,F^H,F^V,F^V^H}.
- F=0 on lines 1-312, F=1 on lines 313-625.
- V=1 on lines 1-22, 311-335 and 624-625; V=0 otherwise (288 active lines per field).
- Blanking fill (also used for the active window on V=1 lines): bytes alternate 80,10, starting with 80 at even offset from the region start.
- Active window on V=0 lines:
  - bt_data = pix_data, clipped: 00 becomes 01, FF becomes FE.
  - No other data transform.
- Latency: bt_data is registered. The byte for position pos appears on bt_data at the clock edge ending the cycle in which the counter equals pos.
- Read handshake:
  - pix_rd is high exactly in cycles with pos in [A0-1, LINE_BYTES-2] on V=0 lines while en=1: 1440 strobes per active line, none on V=1 lines.
  - pix_data is sampled one cycle after each strobe; there is no backpressure.
- field, vblank, hblank and line_num reflect the byte currently on bt_data, i.e. they are aligned to bt_data, not to the counter. hblank=1 for pos < A0.
- frame_start: one cycle high, aligned with bt_data=FF of the line-1 EAV.
- en low:
  - pos<=0, line<=1, bt_data<=10, pix_rd=0, frame_start=0.
  - field/vblank/hblank = 0/1/1.
- en rising: the first emitted byte is FF (line-1 EAV); frame_start pulses with it.
- en falling mid-line: the line is aborted; on the next cycle the en-low state applies and no partial EAV/SAV is completed.
- Reset (async, any time): the same values as en low; counters reset to pos=0, line=1.

Test Plan:
1. Reset, then en=1 -> first bytes FF 00 00 B6, frame_start=1 on the FF; line 1 SAV = FF 00 00 AB; active window of line 1 alternates 80,10; pix_rd never high during lines 1-22.
2. Line 23 -> EAV XY=9D, SAV XY=80; exactly 1440 pix_rd pulses, first in the cycle with pos=A0-1; a ramp on pix_data appears on bt_data in order with one-cycle latency.
3. pix_data=00 and FF during active video -> bt_data=01 and FE respectively; EAV/SAV bytes are unaffected.
4. Line 313 -> EAV F1, SAV EC, field=1; line 336 -> EAV DA, SAV C7; line 625 wraps to line 1 and frame_start pulses once per 625*1728 cycles.
5. en dropped at line 100, pos 900 -> next cycle bt_data=10, pix_rd=0, line_num=1; en reasserted -> stream restarts with FF 00 00 B6.
6. rst pulsed mid-active-line 200 -> outputs immediately (asynchronously) go to the reset values; after release with en=1 the full frame timing matches scenario 1.
